// File: rtl/qpu_exu_alu_lsuagu_if.sv
// LSU AGU bundle: dispatch, ALU adder request, ICB command/response and writeback channels.
// master = the AGU block; slave = dispatch, ALU, memory and commit around it.
interface qpu_exu_alu_lsuagu_if #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
);
  logic              agu_i_valid;
  logic              agu_i_ready;
  logic              agu_i_load;
  logic [XLEN-1:0]   agu_i_rs1;
  logic [XLEN-1:0]   agu_i_imm;
  logic [XLEN-1:0]   agu_i_wdata;
  logic [RIDX_W-1:0] agu_i_rdidx;

  logic              lsu_req_alu;
  logic [XLEN-1:0]   lsu_req_alu_op1;
  logic [XLEN-1:0]   lsu_req_alu_op2;
  logic [XLEN-1:0]   lsu_req_alu_res;

  logic              agu_icb_cmd_valid;
  logic              agu_icb_cmd_ready;
  logic [XLEN-1:0]   agu_icb_cmd_addr;
  logic              agu_icb_cmd_read;
  logic [XLEN-1:0]   agu_icb_cmd_wdata;
  logic              agu_icb_rsp_valid;
  logic              agu_icb_rsp_ready;
  logic [XLEN-1:0]   agu_icb_rsp_rdata;
  logic              agu_icb_rsp_err;

  logic              agu_o_valid;
  logic              agu_o_ready;
  logic              agu_o_wbck_en;
  logic [XLEN-1:0]   agu_o_wbck_wdat;
  logic [RIDX_W-1:0] agu_o_rdidx;
  logic              agu_o_err;
  logic [XLEN-1:0]   agu_o_badaddr;

  modport master (
    input  agu_i_valid, agu_i_load, agu_i_rs1, agu_i_imm, agu_i_wdata, agu_i_rdidx,
    output agu_i_ready,
    output lsu_req_alu, lsu_req_alu_op1, lsu_req_alu_op2,
    input  lsu_req_alu_res,
    output agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
    input  agu_icb_cmd_ready,
    input  agu_icb_rsp_valid, agu_icb_rsp_rdata, agu_icb_rsp_err,
    output agu_icb_rsp_ready,
    output agu_o_valid, agu_o_wbck_en, agu_o_wbck_wdat, agu_o_rdidx, agu_o_err, agu_o_badaddr,
    input  agu_o_ready
  );

  modport slave (
    output agu_i_valid, agu_i_load, agu_i_rs1, agu_i_imm, agu_i_wdata, agu_i_rdidx,
    input  agu_i_ready,
    input  lsu_req_alu, lsu_req_alu_op1, lsu_req_alu_op2,
    output lsu_req_alu_res,
    input  agu_icb_cmd_valid, agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata,
    output agu_icb_cmd_ready,
    output agu_icb_rsp_valid, agu_icb_rsp_rdata, agu_icb_rsp_err,
    input  agu_icb_rsp_ready,
    input  agu_o_valid, agu_o_wbck_en, agu_o_wbck_wdat, agu_o_rdidx, agu_o_err, agu_o_badaddr,
    output agu_o_ready
  );
endinterface

// File: rtl/qpu_exu_alu_lsuagu.sv
// LSU address generation and single-outstanding ICB access sequencer (IDLE -> CMD -> RSP -> WBCK).
// Latency: cmd 1 cycle after accept, writeback 3 cycles with zero-wait memory; misaligned writeback after 1.
module qpu_exu_alu_lsuagu #(
  parameter int XLEN   = 32,
  parameter int RIDX_W = 5
) (
  input logic                    clk,
  input logic                    rst,
  qpu_exu_alu_lsuagu_if.master   agu
);

  typedef enum logic [1:0] {IDLE, CMD, RSP, WBCK} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [RIDX_W-1:0] rdidx_q;
  logic              load_q;
  logic              err_q;

  logic accept;
  logic misaligned;

  assign accept     = (state_q == IDLE) && agu.agu_i_valid;
  assign misaligned = |agu.lsu_req_alu_res[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rdidx_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= agu.lsu_req_alu_res;
        load_q  <= agu.agu_i_load;
        wdata_q <= agu.agu_i_wdata;
        rdidx_q <= agu.agu_i_rdidx;
        err_q   <= misaligned;
        rdata_q <= '0;
      end
      // Only a clean load keeps response data; stores and faults write back zero.
      if ((state_q == RSP) && agu.agu_icb_rsp_valid) begin
        err_q   <= agu.agu_icb_rsp_err;
        rdata_q <= (load_q && !agu.agu_icb_rsp_err) ? agu.agu_icb_rsp_rdata : '0;
      end
    end
  end

  always_comb begin
    state_d               = state_q;
    agu.agu_i_ready       = 1'b0;
    agu.lsu_req_alu       = 1'b0;
    agu.lsu_req_alu_op1   = '0;
    agu.lsu_req_alu_op2   = '0;
    agu.agu_icb_cmd_valid = 1'b0;
    agu.agu_icb_rsp_ready = 1'b0;
    agu.agu_o_valid       = 1'b0;
    case (state_q)
      IDLE: begin
        agu.agu_i_ready = 1'b1;
        if (agu.agu_i_valid) begin
          agu.lsu_req_alu     = 1'b1;
          agu.lsu_req_alu_op1 = agu.agu_i_rs1;
          agu.lsu_req_alu_op2 = agu.agu_i_imm;
          state_d             = misaligned ? WBCK : CMD;
        end
      end
      CMD: begin
        agu.agu_icb_cmd_valid = 1'b1;
        if (agu.agu_icb_cmd_ready) state_d = RSP;
      end
      RSP: begin
        agu.agu_icb_rsp_ready = 1'b1;
        if (agu.agu_icb_rsp_valid) state_d = WBCK;
      end
      WBCK: begin
        agu.agu_o_valid = 1'b1;
        if (agu.agu_o_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign agu.agu_icb_cmd_addr  = addr_q;
  assign agu.agu_icb_cmd_read  = load_q;
  assign agu.agu_icb_cmd_wdata = wdata_q;

  assign agu.agu_o_wbck_en   = (state_q == WBCK) && load_q && !err_q;
  assign agu.agu_o_wbck_wdat = rdata_q;
  assign agu.agu_o_rdidx     = rdidx_q;
  assign agu.agu_o_err       = err_q;
  assign agu.agu_o_badaddr   = err_q ? addr_q : '0;

endmodule

// File: tb/tb_qpu_exu_alu_lsuagu.sv
// Directed bench for the LSU AGU: load, store with backpressure, misaligned, bus error with wrap,
// writeback stall with a queued instruction, and reset during the response phase.
module tb_qpu_exu_alu_lsuagu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  qpu_exu_alu_lsuagu_if #(.XLEN(32), .RIDX_W(5)) bus ();

  qpu_exu_alu_lsuagu #(.XLEN(32), .RIDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .agu (bus.master)
  );

  // Shared ALU adder stand-in.
  assign bus.lsu_req_alu_res = bus.lsu_req_alu_op1 + bus.lsu_req_alu_op2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.agu_i_valid       = 1'b0;
    bus.agu_i_load        = 1'b0;
    bus.agu_i_rs1         = '0;
    bus.agu_i_imm         = '0;
    bus.agu_i_wdata       = '0;
    bus.agu_i_rdidx       = '0;
    bus.agu_icb_cmd_ready = 1'b0;
    bus.agu_icb_rsp_valid = 1'b0;
    bus.agu_icb_rsp_rdata = '0;
    bus.agu_icb_rsp_err   = 1'b0;
    bus.agu_o_ready       = 1'b0;

    // Reset state
    #12;
    chk("rst_i_ready",   32'(bus.agu_i_ready), 32'd1);
    chk("rst_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd0);
    chk("rst_rsp_ready", 32'(bus.agu_icb_rsp_ready), 32'd0);
    chk("rst_o_valid",   32'(bus.agu_o_valid), 32'd0);
    chk("rst_cmd_addr",  bus.agu_icb_cmd_addr, 32'd0);
    chk("rst_req_alu",   32'(bus.lsu_req_alu), 32'd0);
    rst = 1'b0;
    tick();

    // 1: zero-wait load
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = 1'b1;
    bus.agu_i_rs1   = 32'h0000_1000;
    bus.agu_i_imm   = 32'h0000_0010;
    bus.agu_i_rdidx = 5'd5;
    #1;
    chk("t1_req_alu", 32'(bus.lsu_req_alu), 32'd1);
    chk("t1_op1", bus.lsu_req_alu_op1, 32'h0000_1000);
    chk("t1_op2", bus.lsu_req_alu_op2, 32'h0000_0010);
    tick();
    bus.agu_i_valid = 1'b0;
    chk("t1_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd1);
    chk("t1_cmd_addr",  bus.agu_icb_cmd_addr, 32'h0000_1010);
    chk("t1_cmd_read",  32'(bus.agu_icb_cmd_read), 32'd1);
    chk("t1_i_ready",   32'(bus.agu_i_ready), 32'd0);
    bus.agu_icb_cmd_ready = 1'b1;
    tick();
    bus.agu_icb_cmd_ready = 1'b0;
    chk("t1_rsp_ready", 32'(bus.agu_icb_rsp_ready), 32'd1);
    chk("t1_cmd_drop",  32'(bus.agu_icb_cmd_valid), 32'd0);
    bus.agu_icb_rsp_valid = 1'b1;
    bus.agu_icb_rsp_rdata = 32'hDEAD_BEEF;
    tick();
    bus.agu_icb_rsp_valid = 1'b0;
    bus.agu_icb_rsp_rdata = '0;
    chk("t1_o_valid", 32'(bus.agu_o_valid), 32'd1);
    chk("t1_wbck_en", 32'(bus.agu_o_wbck_en), 32'd1);
    chk("t1_wdat",    bus.agu_o_wbck_wdat, 32'hDEAD_BEEF);
    chk("t1_rdidx",   32'(bus.agu_o_rdidx), 32'd5);
    chk("t1_err",     32'(bus.agu_o_err), 32'd0);
    chk("t1_badaddr", bus.agu_o_badaddr, 32'd0);
    bus.agu_o_ready = 1'b1;
    tick();
    bus.agu_o_ready = 1'b0;
    chk("t1_idle_o_valid", 32'(bus.agu_o_valid), 32'd0);
    chk("t1_idle_i_ready", 32'(bus.agu_i_ready), 32'd1);

    // 2: store, cmd_ready held low for 3 cycles
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = 1'b0;
    bus.agu_i_rs1   = 32'h0000_2000;
    bus.agu_i_imm   = 32'hFFFF_FFFC;
    bus.agu_i_wdata = 32'h0000_55AA;
    tick();
    bus.agu_i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd1);
      chk("t2_cmd_addr",  bus.agu_icb_cmd_addr, 32'h0000_1FFC);
      chk("t2_cmd_read",  32'(bus.agu_icb_cmd_read), 32'd0);
      chk("t2_cmd_wdata", bus.agu_icb_cmd_wdata, 32'h0000_55AA);
      if (i == 3) bus.agu_icb_cmd_ready = 1'b1;
      tick();
    end
    bus.agu_icb_cmd_ready = 1'b0;
    bus.agu_icb_rsp_valid = 1'b1;
    bus.agu_icb_rsp_rdata = 32'h1234_5678;
    tick();
    bus.agu_icb_rsp_valid = 1'b0;
    bus.agu_icb_rsp_rdata = '0;
    chk("t2_o_valid", 32'(bus.agu_o_valid), 32'd1);
    chk("t2_wbck_en", 32'(bus.agu_o_wbck_en), 32'd0);
    chk("t2_wdat",    bus.agu_o_wbck_wdat, 32'd0);
    chk("t2_err",     32'(bus.agu_o_err), 32'd0);
    bus.agu_o_ready = 1'b1;
    tick();
    bus.agu_o_ready = 1'b0;

    // 3: misaligned, no bus access
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = 1'b1;
    bus.agu_i_rs1   = 32'h0000_1001;
    bus.agu_i_imm   = 32'd0;
    tick();
    bus.agu_i_valid = 1'b0;
    chk("t3_o_valid",   32'(bus.agu_o_valid), 32'd1);
    chk("t3_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd0);
    chk("t3_err",       32'(bus.agu_o_err), 32'd1);
    chk("t3_badaddr",   bus.agu_o_badaddr, 32'h0000_1001);
    chk("t3_wbck_en",   32'(bus.agu_o_wbck_en), 32'd0);
    chk("t3_wdat",      bus.agu_o_wbck_wdat, 32'd0);
    bus.agu_o_ready = 1'b1;
    tick();
    bus.agu_o_ready = 1'b0;

    // 4: address wrap plus bus error
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = 1'b1;
    bus.agu_i_rs1   = 32'hFFFF_FFFC;
    bus.agu_i_imm   = 32'd8;
    tick();
    bus.agu_i_valid = 1'b0;
    chk("t4_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd1);
    chk("t4_cmd_addr",  bus.agu_icb_cmd_addr, 32'h0000_0004);
    bus.agu_icb_cmd_ready = 1'b1;
    tick();
    bus.agu_icb_cmd_ready = 1'b0;
    bus.agu_icb_rsp_valid = 1'b1;
    bus.agu_icb_rsp_err   = 1'b1;
    bus.agu_icb_rsp_rdata = 32'h0000_AAAA;
    tick();
    bus.agu_icb_rsp_valid = 1'b0;
    bus.agu_icb_rsp_err   = 1'b0;
    bus.agu_icb_rsp_rdata = '0;
    chk("t4_o_valid", 32'(bus.agu_o_valid), 32'd1);
    chk("t4_err",     32'(bus.agu_o_err), 32'd1);
    chk("t4_wbck_en", 32'(bus.agu_o_wbck_en), 32'd0);
    chk("t4_wdat",    bus.agu_o_wbck_wdat, 32'd0);
    chk("t4_badaddr", bus.agu_o_badaddr, 32'h0000_0004);
    bus.agu_o_ready = 1'b1;
    tick();
    bus.agu_o_ready = 1'b0;

    // 5: writeback stalled 5 cycles with a second instruction waiting
    bus.agu_i_valid = 1'b1;
    bus.agu_i_load  = 1'b1;
    bus.agu_i_rs1   = 32'h0000_3000;
    bus.agu_i_imm   = 32'd0;
    bus.agu_i_rdidx = 5'd7;
    tick();
    bus.agu_i_load  = 1'b0;
    bus.agu_i_rs1   = 32'h0000_4000;
    bus.agu_i_imm   = 32'd4;
    bus.agu_i_wdata = 32'h0000_0077;
    bus.agu_icb_cmd_ready = 1'b1;
    tick();
    bus.agu_icb_cmd_ready = 1'b0;
    bus.agu_icb_rsp_valid = 1'b1;
    bus.agu_icb_rsp_rdata = 32'h0000_CAFE;
    tick();
    bus.agu_icb_rsp_valid = 1'b0;
    bus.agu_icb_rsp_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_o_valid", 32'(bus.agu_o_valid), 32'd1);
      chk("t5_wdat",    bus.agu_o_wbck_wdat, 32'h0000_CAFE);
      chk("t5_rdidx",   32'(bus.agu_o_rdidx), 32'd7);
      chk("t5_i_ready", 32'(bus.agu_i_ready), 32'd0);
      chk("t5_req_alu", 32'(bus.lsu_req_alu), 32'd0);
      tick();
    end
    bus.agu_o_ready = 1'b1;
    tick();
    bus.agu_o_ready = 1'b0;
    chk("t5_idle_i_ready", 32'(bus.agu_i_ready), 32'd1);
    chk("t5_idle_o_valid", 32'(bus.agu_o_valid), 32'd0);
    chk("t5_req_alu2",     32'(bus.lsu_req_alu), 32'd1);
    tick();
    bus.agu_i_valid = 1'b0;
    chk("t5_cmd2_valid", 32'(bus.agu_icb_cmd_valid), 32'd1);
    chk("t5_cmd2_addr",  bus.agu_icb_cmd_addr, 32'h0000_4004);
    chk("t5_cmd2_read",  32'(bus.agu_icb_cmd_read), 32'd0);
    bus.agu_icb_cmd_ready = 1'b1;
    tick();
    bus.agu_icb_cmd_ready = 1'b0;

    // 6: reset while waiting for the response, stale response afterwards
    chk("t6_rsp_ready", 32'(bus.agu_icb_rsp_ready), 32'd1);
    rst = 1'b1;
    bus.agu_icb_rsp_valid = 1'b1;
    bus.agu_icb_rsp_rdata = 32'h0BAD_0BAD;
    #1;
    chk("t6_async_i_ready",   32'(bus.agu_i_ready), 32'd1);
    chk("t6_async_rsp_ready", 32'(bus.agu_icb_rsp_ready), 32'd0);
    #3;
    rst = 1'b0;
    tick();
    chk("t6_i_ready",   32'(bus.agu_i_ready), 32'd1);
    chk("t6_rsp_ready", 32'(bus.agu_icb_rsp_ready), 32'd0);
    chk("t6_cmd_valid", 32'(bus.agu_icb_cmd_valid), 32'd0);
    chk("t6_o_valid",   32'(bus.agu_o_valid), 32'd0);
    tick();
    chk("t6_stale_o_valid", 32'(bus.agu_o_valid), 32'd0);
    chk("t6_stale_wdat",    bus.agu_o_wbck_wdat, 32'd0);
    bus.agu_icb_rsp_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
